// File: rtl/game_over_ctrl_pkg.sv
// Shared types and constants for the end-of-game supervisor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package game_over_ctrl_pkg;

    // Result of a finished game as shown on winner_o.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        TIE  = 2'd3
    } game_result_e;

    // Pairs on a standard board.
    localparam int N_PAIRS_DEFAULT = 8;

    // Width of the tick counters (settle, holdoff, blink); tick parameters stay below 2**CNT_W.
    localparam int CNT_W = 8;

    // Winner from the two scores; equal scores are a tie.
    function automatic game_result_e decide_winner(input logic [3:0] p1, input logic [3:0] p2);
        if (p1 > p2) begin
            return P1;
        end
        if (p2 > p1) begin
            return P2;
        end
        return TIE;
    endfunction

endpackage

// File: rtl/game_over_ctrl_if.sv
// Signal bundle between the game FSM side and the end-of-game supervisor.
// Latency: n/a (wires only).
// Backpressure: none; SEL is a one-cycle pulse that is either taken or dropped.
interface game_over_ctrl_if;
    import game_over_ctrl_pkg::*;

    logic         tick_fast_i;
    logic [3:0]   p1_score_i;
    logic [3:0]   p2_score_i;
    logic         led_p1_i;
    logic         led_p2_i;
    logic         btn_sel_i;
    logic         led_p1_o;
    logic         led_p2_o;
    logic         game_over_o;
    logic         freeze_o;
    game_result_e winner_o;
    logic         restart_o;

    // Game FSM / board side: supplies scores, LEDs, tick and SEL.
    modport master (
        output tick_fast_i, p1_score_i, p2_score_i, led_p1_i, led_p2_i, btn_sel_i,
        input  led_p1_o, led_p2_o, game_over_o, freeze_o, winner_o, restart_o
    );

    // Supervisor side.
    modport slave (
        input  tick_fast_i, p1_score_i, p2_score_i, led_p1_i, led_p2_i, btn_sel_i,
        output led_p1_o, led_p2_o, game_over_o, freeze_o, winner_o, restart_o
    );

endinterface

// File: rtl/game_over_ctrl_blink_gen.sv
// Tick-driven blink phase: toggles every BLINK_TICKS enabled ticks, forced ON by clr.
// Latency: phase_nxt_o is the value the phase register takes at the coming edge (0 cycles).
// Backpressure: none; ticks arriving while disabled or during clr are ignored.
module blink_gen
    import game_over_ctrl_pkg::*;
#(
    parameter int BLINK_TICKS = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic en,
    input  logic clr,
    output logic phase_nxt_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             phase_q;

    // Next phase/count: clr restarts the half-period ON, otherwise count enabled ticks.
    always_comb begin
        cnt_nxt     = cnt_q;
        phase_nxt_o = phase_q;
        if (clr) begin
            cnt_nxt     = '0;
            phase_nxt_o = 1'b1;
        end else if (en && tick) begin
            if (cnt_q == LAST) begin
                cnt_nxt     = '0;
                phase_nxt_o = ~phase_q;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
    end

    // Phase and tick count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            phase_q <= phase_nxt_o;
        end
    end

endmodule

// File: rtl/game_over_ctrl.sv
// End-of-game supervisor: detects all pairs found, settles, shows and blinks the winner, requests restart on SEL.
// Latency: all outputs registered; LED pass-through and end-condition-to-game_over are 1 cycle.
// Backpressure: none; SEL before the holdoff has saturated is dropped, not queued.
module game_over_ctrl
    import game_over_ctrl_pkg::*;
#(
    parameter int N_PAIRS       = N_PAIRS_DEFAULT,
    parameter int SETTLE_TICKS  = 12,
    parameter int BLINK_TICKS   = 5,
    parameter int HOLDOFF_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    game_over_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_PLAY    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_RESULT  = 2'd2;
    localparam logic [1:0] ST_RESTART = 2'd3;

    localparam logic [4:0]       N_PAIRS_C   = 5'(N_PAIRS);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(HOLDOFF_TICKS);

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] settle_q;
    logic [CNT_W-1:0] settle_nxt;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_nxt;
    game_result_e     winner_q;
    game_result_e     winner_nxt;
    logic             enter_result;
    logic             sel_ok;
    logic             blink_on;
    logic             led_p1_q;
    logic             led_p2_q;
    logic             led_p1_nxt;
    logic             led_p2_nxt;
    logic             game_over_q;
    logic             restart_q;

    // Five-bit sum cannot overflow; anything at or above the pair count ends the game.
    logic [4:0] score_sum;
    logic       end_cond;
    logic       sum_zero;

    assign score_sum = {1'b0, bus.p1_score_i} + {1'b0, bus.p2_score_i};
    assign end_cond  = (score_sum >= N_PAIRS_C);
    assign sum_zero  = (score_sum == 5'd0);

    // Blink phase restarts ON in the same edge that enters RESULT.
    blink_gen #(
        .BLINK_TICKS (BLINK_TICKS)
    ) u_blink (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (bus.tick_fast_i),
        .en          (state_q == ST_RESULT),
        .clr         (enter_result),
        .phase_nxt_o (blink_on)
    );

    // State transitions, settle/holdoff counters and winner latch.
    always_comb begin
        state_nxt    = state_q;
        settle_nxt   = settle_q;
        hold_nxt     = hold_q;
        winner_nxt   = winner_q;
        enter_result = 1'b0;
        sel_ok       = 1'b0;
        case (state_q)
            ST_PLAY: begin
                winner_nxt = NONE;
                if (end_cond) begin
                    state_nxt  = ST_SETTLE;
                    settle_nxt = '0;
                end
            end
            ST_SETTLE: begin
                // A score correction during the pause cancels the game end.
                if (!end_cond) begin
                    state_nxt = ST_PLAY;
                end else if (bus.tick_fast_i) begin
                    settle_nxt = settle_q + 1'b1;
                    if (settle_q == SETTLE_LAST) begin
                        state_nxt    = ST_RESULT;
                        enter_result = 1'b1;
                        hold_nxt     = '0;
                        winner_nxt   = decide_winner(bus.p1_score_i, bus.p2_score_i);
                    end
                end
            end
            ST_RESULT: begin
                if (bus.tick_fast_i && (hold_q != HOLD_MAX)) begin
                    hold_nxt = hold_q + 1'b1;
                end
                // Uses the registered count, so a SEL on the saturating tick is still too early.
                if (bus.btn_sel_i && (hold_q == HOLD_MAX)) begin
                    state_nxt = ST_RESTART;
                    sel_ok    = 1'b1;
                end
            end
            ST_RESTART: begin
                // Wait for the game FSM to clear the scores before playing again.
                if (sum_zero) begin
                    state_nxt  = ST_PLAY;
                    winner_nxt = NONE;
                end
            end
            default: begin
                state_nxt = ST_PLAY;
            end
        endcase
    end

    // LED source for the coming cycle, chosen by the state being entered.
    always_comb begin
        led_p1_nxt = 1'b0;
        led_p2_nxt = 1'b0;
        case (state_nxt)
            ST_PLAY, ST_SETTLE: begin
                led_p1_nxt = bus.led_p1_i;
                led_p2_nxt = bus.led_p2_i;
            end
            ST_RESULT: begin
                led_p1_nxt = blink_on && ((winner_nxt == P1) || (winner_nxt == TIE));
                led_p2_nxt = blink_on && ((winner_nxt == P2) || (winner_nxt == TIE));
            end
            default: begin
                led_p1_nxt = 1'b0;
                led_p2_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PLAY;
            settle_q    <= '0;
            hold_q      <= '0;
            winner_q    <= NONE;
            led_p1_q    <= 1'b0;
            led_p2_q    <= 1'b0;
            game_over_q <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            settle_q    <= settle_nxt;
            hold_q      <= hold_nxt;
            winner_q    <= winner_nxt;
            led_p1_q    <= led_p1_nxt;
            led_p2_q    <= led_p2_nxt;
            game_over_q <= (state_nxt != ST_PLAY);
            restart_q   <= sel_ok;
        end
    end

    assign bus.led_p1_o    = led_p1_q;
    assign bus.led_p2_o    = led_p2_q;
    assign bus.game_over_o = game_over_q;
    assign bus.freeze_o    = game_over_q;
    assign bus.winner_o    = winner_q;
    assign bus.restart_o   = restart_q;

endmodule

// File: tb/tb_game_over_ctrl.sv
// Bench for game_over_ctrl: directed game scenarios with randomized ticks, LEDs and SEL.
// Latency: n/a.
// Backpressure: n/a.
module tb_game_over_ctrl;
    import game_over_ctrl_pkg::*;

    localparam int NP = 8;
    localparam int ST = 12;
    localparam int BT = 5;
    localparam int HT = 10;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    game_over_ctrl_if bus();

    game_over_ctrl #(
        .N_PAIRS       (NP),
        .SETTLE_TICKS  (ST),
        .BLINK_TICKS   (BT),
        .HOLDOFF_TICKS (HT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: game phase plus elapsed tick counts per phase.
    typedef enum int {M_PLAYING, M_PAUSING, M_SHOWING, M_WAITCLEAR} mmode_t;
    mmode_t m_mode;
    int     m_settle;
    int     m_show;
    int     m_win;
    bit     m_restart;
    bit     e_l1;
    bit     e_l2;

    task automatic model_reset();
        m_mode    = M_PLAYING;
        m_settle  = 0;
        m_show    = 0;
        m_win     = 0;
        m_restart = 0;
        e_l1      = 0;
        e_l2      = 0;
    endtask

    // One clock edge of the reference behaviour using the inputs present at that edge.
    task automatic model_step();
        int  sum;
        int  p1;
        int  p2;
        bit  on;
        p1  = int'(bus.p1_score_i);
        p2  = int'(bus.p2_score_i);
        sum = p1 + p2;
        m_restart = 0;
        case (m_mode)
            M_PLAYING: begin
                if (sum >= NP) begin
                    m_mode   = M_PAUSING;
                    m_settle = 0;
                end
            end
            M_PAUSING: begin
                if (sum < NP) begin
                    m_mode = M_PLAYING;
                end else if (bus.tick_fast_i) begin
                    m_settle++;
                    if (m_settle == ST) begin
                        m_mode = M_SHOWING;
                        m_show = 0;
                        m_win  = (p1 > p2) ? 1 : ((p2 > p1) ? 2 : 3);
                    end
                end
            end
            M_SHOWING: begin
                if (bus.btn_sel_i && (m_show >= HT)) begin
                    m_mode    = M_WAITCLEAR;
                    m_restart = 1;
                end else if (bus.tick_fast_i) begin
                    m_show++;
                end
            end
            default: begin
                if (sum == 0) begin
                    m_mode = M_PLAYING;
                    m_win  = 0;
                end
            end
        endcase
        case (m_mode)
            M_PLAYING, M_PAUSING: begin
                e_l1 = bus.led_p1_i;
                e_l2 = bus.led_p2_i;
            end
            M_SHOWING: begin
                on   = ((m_show / BT) % 2) == 0;
                e_l1 = on && (m_win == 1 || m_win == 3);
                e_l2 = on && (m_win == 2 || m_win == 3);
            end
            default: begin
                e_l1 = 0;
                e_l2 = 0;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("led_p1",    4'(bus.led_p1_o),    4'(e_l1));
        chk("led_p2",    4'(bus.led_p2_o),    4'(e_l2));
        chk("game_over", 4'(bus.game_over_o), 4'(m_mode != M_PLAYING));
        chk("freeze",    4'(bus.freeze_o),    4'(m_mode != M_PLAYING));
        chk("winner",    4'(bus.winner_o),    4'(m_win));
        chk("restart",   4'(bus.restart_o),   4'(m_restart));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic sc(input int p1, input int p2);
        bus.p1_score_i = 4'(p1);
        bus.p2_score_i = 4'(p2);
    endtask

    // Explicit tick/SEL with random turn LEDs, then one checked cycle.
    task automatic drive(input bit tick, input bit sel);
        bus.tick_fast_i = tick;
        bus.btn_sel_i   = sel;
        bus.led_p1_i    = 1'($urandom_range(0, 1));
        bus.led_p2_i    = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic run(input int n, input int tick_div, input int sel_pct);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, tick_div - 1) == 0, int'($urandom_range(0, 99)) < sel_pct);
        end
    endtask

    task automatic wait_mode(input mmode_t tgt, input int budget, input int sel_pct);
        bit found;
        found = (m_mode == tgt);
        for (int i = 0; i < budget && !found; i++) begin
            run(1, 3, sel_pct);
            found = (m_mode == tgt);
        end
        n_vec++;
        assert (found) else begin
            n_miss++;
            $error("FAIL wait_%s: timed out in %s after %0d cycles", tgt.name(), m_mode.name(), budget);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.tick_fast_i = 1'b0;
        bus.btn_sel_i   = 1'b0;
        bus.led_p1_i    = 1'b0;
        bus.led_p2_i    = 1'b0;
        sc(0, 0);
        model_reset();
        #2;
        check_all();
        #10;
        rst_n = 1'b1;

        // Normal play: random scores below the end condition, LEDs pass through.
        for (int i = 0; i < 30; i++) begin
            int a;
            a = int'($urandom_range(0, NP - 1));
            sc(a, int'($urandom_range(0, NP - 1 - a)));
            run(1, 3, 20);
        end

        // Win P1: 4/3 then 5/3.
        sc(4, 3);
        run(5, 3, 0);
        sc(5, 3);
        drive(0, 0);
        chk("go_rise", 4'(bus.game_over_o), 4'd1);
        wait_mode(M_SHOWING, 300, 0);
        chk("p1_winner", 4'(bus.winner_o), 4'd1);
        chk("p1_led_entry", {2'b0, bus.led_p1_o, bus.led_p2_o}, 4'b0010);
        run(60, 3, 0);
        wait_mode(M_WAITCLEAR, 400, 10);
        run(20, 3, 20);
        chk("restart_hold", 4'(bus.game_over_o), 4'd1);
        sc(0, 0);
        drive(0, 0);
        chk("p1_cleared", 4'(bus.winner_o), 4'd0);

        // Tie at 4/4: both LEDs blink in phase, ON at entry.
        sc(4, 4);
        wait_mode(M_SHOWING, 300, 0);
        chk("tie_winner", 4'(bus.winner_o), 4'd3);
        chk("tie_led_entry", {2'b0, bus.led_p1_o, bus.led_p2_o}, 4'b0011);
        run(40, 3, 0);
        wait_mode(M_WAITCLEAR, 400, 10);
        sc(0, 0);
        run(5, 3, 0);

        // Settle abort after 6 ticks.
        sc(4, 4);
        drive(0, 0);
        for (int i = 0; i < 6; i++) drive(1, 0);
        sc(3, 4);
        drive(0, 0);
        chk("abort_go", 4'(bus.game_over_o), 4'd0);
        chk("abort_win", 4'(bus.winner_o), 4'd0);
        run(10, 3, 0);

        // Holdoff boundary with a P2 win and a sum above the pair count.
        sc(2, 9);
        drive(0, 0);
        for (int i = 0; i < ST; i++) drive(1, 0);
        chk("p2_winner", 4'(bus.winner_o), 4'd2);
        for (int i = 0; i < HT - 1; i++) drive(1, 0);
        drive(0, 1);
        chk("sel_tick9", 4'(bus.restart_o), 4'd0);
        drive(1, 1);
        chk("sel_on_sat_tick", 4'(bus.restart_o), 4'd0);
        drive(0, 1);
        chk("sel_accepted", 4'(bus.restart_o), 4'd1);
        drive(0, 0);
        chk("restart_one_cycle", 4'(bus.restart_o), 4'd0);
        run(10, 3, 30);
        sc(0, 0);
        drive(0, 0);
        chk("p2_cleared", 4'(bus.winner_o), 4'd0);

        // Reset in the middle of RESULT.
        sc(15, 15);
        wait_mode(M_SHOWING, 300, 0);
        run(7, 3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        sc(0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #1;
        rst_n = 1'b1;
        run(10, 3, 0);

        // Random games with occasional score jumps.
        for (int g = 0; g < 400; g++) begin
            if ($urandom_range(0, 19) == 0) begin
                int kind;
                int a;
                kind = int'($urandom_range(0, 9));
                if (kind < 4) begin
                    sc(0, 0);
                end else if (kind < 7) begin
                    a = int'($urandom_range(0, 15));
                    sc(a, int'($urandom_range((a >= NP) ? 0 : NP - a, 15)));
                end else begin
                    a = int'($urandom_range(0, NP - 1));
                    sc(a, int'($urandom_range(0, NP - 1 - a)));
                end
            end
            run(1, 3, 15);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/game_over_ctrl.md
# game_over_ctrl

End-of-game supervisor for the two-player memory game. It sits directly downstream of `fsm_memoria`. It consumes the per-player scores and turn LEDs, and the 20 Hz fast tick. It detects when all pairs are found and holds a settle pause so the last reveal stays visible. It then latches the result (P1, P2 or tie), blinks the winner's LED(s), freezes the turn timer, and issues a one-cycle restart request when SEL is pressed.

## Interface
Parameters:
- `N_PAIRS`, default 8: total pairs on the board; the game ends when the score sum reaches this value.
- `SETTLE_TICKS`, default 12: number of `tick_fast_i` ticks between the last match and result display.
- `BLINK_TICKS`, default 5: ticks per LED blink half-period (2 Hz toggle at a 20 Hz tick).
- `HOLDOFF_TICKS`, default 10: ticks in RESULT before SEL is accepted.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `tick_fast_i`  in  1  one-cycle 20 Hz strobe.
- `p1_score_i`  in  4  player 1 pairs found.
- `p2_score_i`  in  4  player 2 pairs found.
- `led_p1_i`  in  1  turn LED from the game FSM.
- `led_p2_i`  in  1  turn LED from the game FSM.
- `btn_sel_i`  in  1  debounced, gated one-cycle SEL pulse.
- `led_p1_o`  out  1  LED to the pin.
- `led_p2_o`  out  1  LED to the pin.
- `game_over_o`  out  1  high in SETTLE, RESULT and RESTART.
- `freeze_o`  out  1  timer pause request; identical to `game_over_o`.
- `winner_o`  out  2  `game_result_e`: NONE=0, P1=1, P2=2, TIE=3.
- `restart_o`  out  1  one-cycle request to soft-restart the game.

## Operation
- Score sum: `sum = p1_score_i + p2_score_i`, computed 5 bits wide with no overflow. The end condition is `sum >= N_PAIRS`. Values above `N_PAIRS` are treated as the end condition.
- PLAY state:
  - `led_*_o` are registered copies of `led_*_i`; `winner_o` = NONE.
  - When the end condition holds, go to SETTLE and load the tick counter with 0.
- SETTLE state:
  - The counter increments on each `tick_fast_i`. `led_*_o` continue to pass through.
  - If `sum` drops below `N_PAIRS`, return to PLAY; `game_over_o` deasserts.
  - On the tick that makes the count equal `SETTLE_TICKS`, go to RESULT.
  - The winner is latched on that transition from the scores in that cycle: P1 if p1>p2, P2 if p2>p1, TIE otherwise.
- RESULT state:
  - A blink phase toggles every `BLINK_TICKS` ticks, starting ON at entry.
  - P1: `led_p1_o` = phase, `led_p2_o` = 0. P2: mirror image. TIE: both LEDs = phase.
  - The holdoff counter counts ticks up to `HOLDOFF_TICKS` and then saturates.
  - `btn_sel_i` is accepted only if the holdoff had already saturated before that cycle. Earlier pulses are dropped, not queued.
  - An accepted SEL goes to RESTART.
- RESTART state:
  - `restart_o` is high for exactly the first cycle in RESTART.
  - Both LEDs are 0 and `winner_o` keeps its latched value.
  - Stay in RESTART until `sum == 0`, then go to PLAY; `winner_o` becomes NONE on entry to PLAY.
  - If the scores never clear, the block remains in RESTART. This is the required behaviour, not a fault.
- Reset at any point: all outputs return to their reset values next to the reset assertion, and the state becomes PLAY.

## Timing
- Reset values: state PLAY, all counters 0, `led_p1_o` = `led_p2_o` = 0, `game_over_o` = `freeze_o` = 0, `winner_o` = NONE, `restart_o` = 0.
- All outputs are registered. LED pass-through latency is 1 cycle.
- End condition to `game_over_o` high: 1 cycle.
- From PLAY→SETTLE to RESULT: exactly `SETTLE_TICKS` `tick_fast_i` strobes.
- Accepted SEL to `restart_o` high: 1 cycle; the pulse lasts 1 cycle.
- If a tick and a SEL arrive in the same cycle in which the holdoff reaches saturation, the SEL is ignored.
- If the end condition and `sum == 0` are both seen in RESTART, `sum == 0` wins.

## Structure
- `lab3_params` gains the `game_result_e` typedef (2-bit enum) and the `N_PAIRS_DEFAULT` constant. `card_state_e` stays there unchanged.
- One sub-module, `blink_gen`: a tick-driven toggle with an enable and synchronous phase reset, parameterised by `BLINK_TICKS`.
- Top-level integration:
  - `freeze_o` drives `timer_15s.pause`.
  - `restart_o` feeds the game FSM's soft-restart input.

## Test plan
- Win P1: scores go 4/3 → 5/3 in PLAY. `game_over_o` rises 1 cycle later. After 12 ticks, `winner_o` = 1, `led_p1_o` toggles every 5 ticks and `led_p2_o` = 0.
- Tie: scores reach 4/4. After settle, `winner_o` = 3 and both LEDs blink in phase, ON at entry.
- Settle abort: sum = 8, then the scores drop to 3/4 after 6 ticks. The state is back in PLAY, `game_over_o` = 0 and `winner_o` = 0.
- Holdoff:
  - SEL at tick 9 in RESULT: no `restart_o`.
  - SEL after tick 10: `restart_o` is high for exactly 1 cycle, then stays 0.
  - Scores cleared to 0/0: PLAY is re-entered and `winner_o` = 0.
- Reset mid-RESULT: assert `rst_n` = 0. All outputs go to 0 or NONE immediately. After release with scores 0/0, the LEDs follow `led_*_i` with 1-cycle latency.
